// File: rtl/pattern_11011_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_11011_tx_if
//  Description : Load handshake, serial line and golden-model bundle for
//                pattern_11011_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pattern_11011_tx_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  localparam int LEN_W = $clog2(WIDTH) + 1;

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] data_in;
  logic [LEN_W-1:0] len_in;
  logic             hold;
  logic             clr_cnt;
  logic             n;
  logic             n_valid;
  logic             done;
  logic             err;
  logic             exp_d;
  logic [CNT_W-1:0] exp_cnt;

  modport master (
    output load_valid, data_in, len_in, hold, clr_cnt,
    input  load_ready, n, n_valid, done, err, exp_d, exp_cnt
  );

  modport slave (
    input  load_valid, data_in, len_in, hold, clr_cnt,
    output load_ready, n, n_valid, done, err, exp_d, exp_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pattern_11011_tx.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_11011_tx
//  Description : Serialises MSB-first frames onto n and runs a golden Mealy
//                11011 overlapping detector with a saturating match counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_11011_tx #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  pattern_11011_tx_if.slave bus
);

  localparam int               LEN_W   = $clog2(WIDTH) + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_cnt_q;
  logic             n_q;
  logic             n_valid_q;
  logic             done_q;
  logic             err_q;
  logic [3:0]       hist_q;
  logic [CNT_W-1:0] exp_cnt_q;
  logic [CNT_W-1:0] exp_cnt_d;
  logic             w_len_ok;
  logic             w_exp_d;

  assign w_len_ok = (bus.len_in != '0) && (bus.len_in <= LEN_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      n_q       <= 1'b0;
      n_valid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      n_q       <= 1'b0;
      n_valid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.load_valid) begin
            if (w_len_ok) begin
              sr_q      <= bus.data_in;
              len_q     <= bus.len_in;
              bit_cnt_q <= '0;
              state_q   <= SHIFT;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          // A held cycle leaves the line at 0 and keeps the pending bit in place.
          if (!bus.hold) begin
            if (bit_cnt_q == len_q) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              n_q       <= sr_q[WIDTH-1];
              n_valid_q <= 1'b1;
              sr_q      <= {sr_q[WIDTH-2:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + LEN_W'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The reference detector watches the raw line, idle and held zeros included.
  assign w_exp_d = (hist_q == 4'b1101) && n_q;

  always_comb begin
    exp_cnt_d = exp_cnt_q;
    if (bus.clr_cnt) begin
      exp_cnt_d = '0;
    end else if (w_exp_d && (exp_cnt_q != CNT_SAT)) begin
      exp_cnt_d = exp_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q    <= '0;
      exp_cnt_q <= '0;
    end else begin
      hist_q    <= {hist_q[2:0], n_q};
      exp_cnt_q <= exp_cnt_d;
    end
  end

  assign bus.load_ready = (state_q == IDLE);
  assign bus.n          = n_q;
  assign bus.n_valid    = n_valid_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.exp_d      = w_exp_d;
  assign bus.exp_cnt    = exp_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_11011_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_11011_tx
//  Description : Directed self-checking bench for pattern_11011_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_11011_tx;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  pattern_11011_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  pattern_11011_tx_if #(.WIDTH(WIDTH), .CNT_W(2))     bus2 ();

  pattern_11011_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pattern_11011_tx #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.load_valid = 0; bus.data_in = '0; bus.len_in = '0; bus.hold = 0; bus.clr_cnt = 0;
    bus2.load_valid = 0; bus2.data_in = '0; bus2.len_in = '0; bus2.hold = 0; bus2.clr_cnt = 0;
    #2;
    checks++; if (bus.load_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", bus.load_ready); end
    checks++; if ({bus.n, bus.n_valid, bus.done, bus.err} !== 4'b0000) begin fails++; $display("FAIL reset_outs: got %b expected 0000", {bus.n, bus.n_valid, bus.done, bus.err}); end
    checks++; if (bus.exp_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt: got %0d expected 0", bus.exp_cnt); end
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single_match;
    logic [4:0] pat;
    pat = 5'b11011;
    bus.data_in = 16'hD800; bus.len_in = 5; bus.load_valid = 1;
    tick;
    bus.load_valid = 0;
    checks++; if ({bus.load_ready, bus.n_valid} !== 2'b00) begin fails++; $display("FAIL single_T: got ready/valid %b expected 00", {bus.load_ready, bus.n_valid}); end
    for (int k = 1; k <= 5; k++) begin
      tick;
      checks++; if ({bus.n, bus.n_valid} !== {pat[5-k], 1'b1}) begin fails++; $display("FAIL single_bit%0d: got n/valid %b expected %b1", k, {bus.n, bus.n_valid}, pat[5-k]); end
      checks++; if (bus.exp_d !== (k == 5)) begin fails++; $display("FAIL single_expd%0d: got %b expected %b", k, bus.exp_d, (k == 5)); end
    end
    tick;
    checks++; if ({bus.done, bus.n_valid} !== 2'b10) begin fails++; $display("FAIL single_done: got done/valid %b expected 10", {bus.done, bus.n_valid}); end
    checks++; if (bus.exp_cnt !== 8'd1) begin fails++; $display("FAIL single_cnt: got %0d expected 1", bus.exp_cnt); end
    tick;
    checks++; if ({bus.load_ready, bus.done} !== 2'b10) begin fails++; $display("FAIL single_ready: got ready/done %b expected 10", {bus.load_ready, bus.done}); end
  endtask

  task automatic test_overlap;
    logic [7:0] pat;
    pat = 8'b11011011;
    bus.clr_cnt = 1;
    tick;
    bus.clr_cnt = 0;
    checks++; if (bus.exp_cnt !== 8'd0) begin fails++; $display("FAIL clr_cnt: got %0d expected 0", bus.exp_cnt); end
    bus.data_in = 16'hDB00; bus.len_in = 8; bus.load_valid = 1;
    tick;
    bus.load_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      tick;
      checks++; if ({bus.n, bus.n_valid} !== {pat[8-k], 1'b1}) begin fails++; $display("FAIL overlap_bit%0d: got n/valid %b expected %b1", k, {bus.n, bus.n_valid}, pat[8-k]); end
      checks++; if (bus.exp_d !== (k == 5 || k == 8)) begin fails++; $display("FAIL overlap_expd%0d: got %b expected %b", k, bus.exp_d, (k == 5 || k == 8)); end
    end
    tick;
    checks++; if (bus.done !== 1'b1) begin fails++; $display("FAIL overlap_done: got %b expected 1", bus.done); end
    checks++; if (bus.exp_cnt !== 8'd2) begin fails++; $display("FAIL overlap_cnt: got %0d expected 2", bus.exp_cnt); end
    tick;
  endtask

  task automatic test_bad_len;
    logic [4:0] lens [2];
    lens[0] = 5'd0;
    lens[1] = 5'd17;
    for (int i = 0; i < 2; i++) begin
      bus.data_in = 16'hD800; bus.len_in = lens[i]; bus.load_valid = 1;
      tick;
      bus.load_valid = 0;
      checks++; if ({bus.err, bus.load_ready, bus.n_valid} !== 3'b110) begin fails++; $display("FAIL badlen%0d_err: got err/ready/valid %b expected 110", lens[i], {bus.err, bus.load_ready, bus.n_valid}); end
      tick;
      checks++; if ({bus.err, bus.load_ready, bus.n_valid} !== 3'b010) begin fails++; $display("FAIL badlen%0d_after: got err/ready/valid %b expected 010", lens[i], {bus.err, bus.load_ready, bus.n_valid}); end
    end
  endtask

  task automatic test_hold;
    logic [4:0] pat;
    pat = 5'b11011;
    bus.data_in = 16'hD800; bus.len_in = 5; bus.load_valid = 1;
    tick;
    bus.load_valid = 0;
    for (int k = 1; k <= 2; k++) begin
      tick;
      checks++; if ({bus.n, bus.n_valid} !== {pat[5-k], 1'b1}) begin fails++; $display("FAIL hold_pre_bit%0d: got n/valid %b expected %b1", k, {bus.n, bus.n_valid}, pat[5-k]); end
    end
    bus.hold = 1;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++; if ({bus.n, bus.n_valid} !== 2'b00) begin fails++; $display("FAIL hold_gap%0d: got n/valid %b expected 00", c, {bus.n, bus.n_valid}); end
    end
    bus.hold = 0;
    for (int k = 3; k <= 5; k++) begin
      tick;
      checks++; if ({bus.n, bus.n_valid, bus.exp_d} !== {pat[5-k], 2'b10}) begin fails++; $display("FAIL hold_post_bit%0d: got n/valid/expd %b expected %b10", k, {bus.n, bus.n_valid, bus.exp_d}, pat[5-k]); end
    end
    tick;
    checks++; if (bus.done !== 1'b1) begin fails++; $display("FAIL hold_done: got %b expected 1 at T+9", bus.done); end
    checks++; if (bus.exp_cnt !== 8'd2) begin fails++; $display("FAIL hold_cnt: got %0d expected 2", bus.exp_cnt); end
    tick;
  endtask

  task automatic test_max_len;
    logic [15:0] pat;
    pat = 16'hA5C3;
    bus.data_in = pat; bus.len_in = 16; bus.load_valid = 1;
    tick;
    for (int k = 1; k <= 16; k++) begin
      tick;
      checks++; if ({bus.n, bus.n_valid} !== {pat[16-k], 1'b1}) begin fails++; $display("FAIL maxlen_bit%0d: got n/valid %b expected %b1", k, {bus.n, bus.n_valid}, pat[16-k]); end
    end
    tick;
    checks++; if ({bus.done, bus.load_ready} !== 2'b10) begin fails++; $display("FAIL maxlen_done: got done/ready %b expected 10", {bus.done, bus.load_ready}); end
    bus.load_valid = 0;
    tick;
    checks++; if ({bus.load_ready, bus.exp_cnt} !== {1'b1, 8'd2}) begin fails++; $display("FAIL maxlen_end: got ready/cnt %b/%0d expected 1/2", bus.load_ready, bus.exp_cnt); end
  endtask

  task automatic test_reset_mid_shift;
    bus.data_in = 16'hD800; bus.len_in = 5; bus.load_valid = 1;
    tick;
    bus.load_valid = 0;
    tick; tick;
    checks++; if ({bus.n, bus.n_valid} !== 2'b11) begin fails++; $display("FAIL rstmid_pre: got n/valid %b expected 11", {bus.n, bus.n_valid}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.n, bus.n_valid, bus.load_ready} !== 3'b001) begin fails++; $display("FAIL rstmid_async: got n/valid/ready %b expected 001", {bus.n, bus.n_valid, bus.load_ready}); end
    checks++; if (bus.exp_cnt !== 8'd0) begin fails++; $display("FAIL rstmid_cnt: got %0d expected 0", bus.exp_cnt); end
    rst = 1'b0;
    tick;
    checks++; if ({bus.n_valid, bus.load_ready} !== 2'b01) begin fails++; $display("FAIL rstmid_idle: got valid/ready %b expected 01", {bus.n_valid, bus.load_ready}); end
  endtask

  task automatic test_counter_sat;
    logic [1:0] want;
    for (int i = 0; i < 4; i++) begin
      bus2.data_in = 16'hD800; bus2.len_in = 5; bus2.load_valid = 1;
      tick;
      bus2.load_valid = 0;
      repeat (6) tick;
      want = (i >= 2) ? 2'd3 : 2'(i + 1);
      checks++; if ({bus2.done, bus2.exp_cnt} !== {1'b1, want}) begin fails++; $display("FAIL sat_frame%0d: got done/cnt %b/%0d expected 1/%0d", i, bus2.done, bus2.exp_cnt, want); end
      tick;
    end
    bus2.clr_cnt = 1;
    tick;
    bus2.clr_cnt = 0;
    checks++; if (bus2.exp_cnt !== 2'd0) begin fails++; $display("FAIL sat_clear: got %0d expected 0", bus2.exp_cnt); end
  endtask

  initial begin
    test_reset;
    test_single_match;
    test_overlap;
    test_bad_len;
    test_hold;
    test_max_len;
    test_reset_mid_shift;
    test_counter_sat;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
